// File: rtl/pipe_pkg.sv
// Shared pipeline-register types and default widths for the
// ID/EX, EX/MEM and MEM/WB handshake registers.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam int DATA_W_DEF = 32;
   localparam int CTRL_W_DEF = 4;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid flag plus payload, with clear and load.
// Clear wins over load; an empty slot always reads as zero.
module pipe_slot #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] set_data,
   input  logic [CTRL_W-1:0] set_control,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] control
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         valid   <= 1'b0;
         data    <= '0;
         control <= '0;
      end else if (load) begin
         valid   <= 1'b1;
         data    <= set_data;
         control <= set_control;
      end
   end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM register with valid/ready handshake and a two-entry skid
// buffer; ex_ready is registered so MEM stalls never reach EX combinationally.
module ex_mem_skid_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_data,
   input  logic [CTRL_W-1:0] ex_control,
   output logic              ex_ready,
   output logic              mem_valid,
   output logic [DATA_W-1:0] mem_data,
   output logic [CTRL_W-1:0] mem_control,
   input  logic              mem_ready,
   output logic [CNT_W-1:0]  stall_cnt
);

   state_t state;

   logic in_xfer;
   logic out_xfer;

   logic              main_load;
   logic              main_clear;
   logic [DATA_W-1:0] main_src_data;
   logic [CTRL_W-1:0] main_src_control;

   logic              skid_load;
   logic              skid_clear;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_control;

   assign in_xfer  = ex_valid && ex_ready;
   assign out_xfer = mem_valid && mem_ready;

   // Main refills from skid whenever skid holds the older entry.
   assign main_src_data    = skid_valid ? skid_data : ex_data;
   assign main_src_control = skid_valid ? skid_control : ex_control;

   always_comb begin
      main_load  = 1'b0;
      main_clear = flush;
      skid_load  = 1'b0;
      skid_clear = flush;
      if (!flush) begin
         unique case (state)
            EMPTY: main_load = in_xfer;
            BUSY: begin
               if (in_xfer && out_xfer) main_load = 1'b1;
               else if (in_xfer)        skid_load = 1'b1;
               else if (out_xfer)       main_clear = 1'b1;
            end
            FULL: begin
               main_load  = out_xfer;
               skid_clear = out_xfer;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state    <= EMPTY;
         ex_ready <= 1'b1;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_xfer) state <= BUSY;
            end
            BUSY: begin
               if (in_xfer && !out_xfer) begin
                  state    <= FULL;
                  ex_ready <= 1'b0;
               end else if (!in_xfer && out_xfer) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (out_xfer) begin
                  state    <= BUSY;
                  ex_ready <= 1'b1;
               end
            end
            default: begin
               state    <= EMPTY;
               ex_ready <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (mem_valid && !mem_ready
                   && stall_cnt != {CNT_W{1'b1}}) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   pipe_slot #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W)
   ) u_main (
      .clk        (clk),
      .reset      (reset),
      .clear      (main_clear),
      .load       (main_load),
      .set_data   (main_src_data),
      .set_control(main_src_control),
      .valid      (mem_valid),
      .data       (mem_data),
      .control    (mem_control)
   );

   pipe_slot #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W)
   ) u_skid (
      .clk        (clk),
      .reset      (reset),
      .clear      (skid_clear),
      .load       (skid_load),
      .set_data   (ex_data),
      .set_control(ex_control),
      .valid      (skid_valid),
      .data       (skid_data),
      .control    (skid_control)
   );

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg: directed stimulus pushes expected
// entries, a negedge monitor pops them on every out transfer.
module tb_ex_mem_skid_reg;

   localparam int DW = 32;
   localparam int CW = 4;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          flush = 1'b0;
   logic          ex_valid = 1'b0;
   logic [DW-1:0] ex_data = '0;
   logic [CW-1:0] ex_control = '0;
   logic          ex_ready;
   logic          mem_valid;
   logic [DW-1:0] mem_data;
   logic [CW-1:0] mem_control;
   logic          mem_ready = 1'b0;
   logic [NW-1:0] stall_cnt;

   int tests = 0;
   int fails = 0;

   logic [CW+DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   ex_mem_skid_reg #(
      .DATA_W(DW),
      .CTRL_W(CW),
      .CNT_W (NW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .ex_valid   (ex_valid),
      .ex_data    (ex_data),
      .ex_control (ex_control),
      .ex_ready   (ex_ready),
      .mem_valid  (mem_valid),
      .mem_data   (mem_data),
      .mem_control(mem_control),
      .mem_ready  (mem_ready),
      .stall_cnt  (stall_cnt)
   );

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v,
                        input logic [DW-1:0] d,
                        input logic [CW-1:0] c);
      ex_valid   = v;
      ex_data    = d;
      ex_control = c;
   endtask

   task automatic expect_out(input logic [DW-1:0] d,
                             input logic [CW-1:0] c);
      exp_q.push_back({c, d});
   endtask

   // Monitor: an out transfer happens at the coming edge unless reset.
   always @(negedge clk) begin
      if (!reset && mem_valid === 1'b1 && mem_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", {28'd0, mem_control, mem_data}, 64'd0);
         end else begin
            check("sb_out", {28'd0, mem_control, mem_data},
                  {28'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      // Reset
      reset = 1'b1;
      step();
      check("rst_ex_ready", 64'(ex_ready), 64'd1);
      check("rst_mem_valid", 64'(mem_valid), 64'd0);
      check("rst_mem_data", 64'(mem_data), 64'd0);
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      reset = 1'b0;

      // Streaming with mem_ready held high
      mem_ready = 1'b1;
      drive(1'b1, 32'hA5A5A5A5, 4'd1);
      expect_out(32'hA5A5A5A5, 4'd1);
      step();
      check("strm_0", 64'(mem_data), 64'hA5A5A5A5);
      drive(1'b1, 32'h5A5A5A5A, 4'd0);
      expect_out(32'h5A5A5A5A, 4'd0);
      step();
      check("strm_1", 64'(mem_data), 64'h5A5A5A5A);
      check("strm_1_v", 64'(mem_valid), 64'd1);
      drive(1'b1, 32'hFFFFFFFF, 4'd1);
      expect_out(32'hFFFFFFFF, 4'd1);
      step();
      check("strm_2", 64'(mem_data), 64'hFFFFFFFF);
      check("strm_2_v", 64'(mem_valid), 64'd1);
      drive(1'b0, '0, '0);
      step();
      check("drain_v", 64'(mem_valid), 64'd0);
      check("drain_data", 64'(mem_data), 64'd0);
      check("drain_ctrl", 64'(mem_control), 64'd0);

      // Backpressure: main then skid fill, third entry refused
      mem_ready = 1'b0;
      drive(1'b1, 32'h11111111, 4'd2);
      expect_out(32'h11111111, 4'd2);
      step();
      check("bp_rdy0", 64'(ex_ready), 64'd1);
      check("bp_data0", 64'(mem_data), 64'h11111111);
      drive(1'b1, 32'h22222222, 4'd3);
      expect_out(32'h22222222, 4'd3);
      step();
      check("bp_rdy1", 64'(ex_ready), 64'd0);
      check("bp_data1", 64'(mem_data), 64'h11111111);
      drive(1'b1, 32'h33333333, 4'd4);
      step();
      check("bp_rdy2", 64'(ex_ready), 64'd0);
      check("bp_data2", 64'(mem_data), 64'h11111111);
      check("bp_cnt", 64'(stall_cnt), 64'd2);
      mem_ready = 1'b1;
      expect_out(32'h33333333, 4'd4);
      step();
      check("bp_rel_rdy", 64'(ex_ready), 64'd1);
      check("bp_rel_data", 64'(mem_data), 64'h22222222);
      step();
      drive(1'b0, '0, '0);
      check("bp_33_data", 64'(mem_data), 64'h33333333);
      step();
      check("bp_empty", 64'(mem_valid), 64'd0);

      // Flush in FULL with a simultaneous offer
      mem_ready = 1'b0;
      drive(1'b1, 32'h66666666, 4'd1);
      step();
      drive(1'b1, 32'h77777777, 4'd2);
      step();
      check("fl_full_rdy", 64'(ex_ready), 64'd0);
      flush = 1'b1;
      drive(1'b1, 32'h44444444, 4'd3);
      step();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      check("fl_valid", 64'(mem_valid), 64'd0);
      check("fl_data", 64'(mem_data), 64'd0);
      check("fl_ctrl", 64'(mem_control), 64'd0);
      check("fl_ready", 64'(ex_ready), 64'd1);
      check("fl_cnt", 64'(stall_cnt), 64'd4);
      mem_ready = 1'b1;
      repeat (3) step();

      // Stall counter saturation, survives flush, cleared by reset
      mem_ready = 1'b0;
      drive(1'b1, 32'h88888888, 4'd5);
      step();
      drive(1'b0, '0, '0);
      repeat (20) step();
      check("sat_cnt", 64'(stall_cnt), 64'd15);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("sat_fl_cnt", 64'(stall_cnt), 64'd15);
      check("sat_fl_v", 64'(mem_valid), 64'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("sat_rst_cnt", 64'(stall_cnt), 64'd0);

      // Reset in BUSY with both handshakes active
      mem_ready = 1'b1;
      drive(1'b1, 32'h99999999, 4'd6);
      step();
      check("rb_data", 64'(mem_data), 64'h99999999);
      drive(1'b1, 32'hAAAAAAAA, 4'd7);
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(1'b0, '0, '0);
      check("rb_rdy", 64'(ex_ready), 64'd1);
      check("rb_valid", 64'(mem_valid), 64'd0);
      check("rb_data0", 64'(mem_data), 64'd0);
      check("rb_ctrl0", 64'(mem_control), 64'd0);
      check("rb_cnt", 64'(stall_cnt), 64'd0);
      repeat (3) step();

      check("sb_left", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
